program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Sequential back end of the CPU's control path. It consumes the next-state (ns), PC-select (ps) and ROM-enable (rom_enable) outputs of the combinational decoder.
- It holds the PC, the instruction register (IR) and the 1-bit two-cycle state flop that feeds back into the decoder.
- It detects end-of-execution (EOE) and freezes the core.
- It sits between the program ROM and the decoder/datapath.

Parameters:
- PC_W, 8, program-counter and ROM address width.
- IW, 8, instruction width. Opcode is instr[IW-1:IW-4].
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- ns  input  1  next-state bit from the decoder.
- ps  input  2  PC select: 00 hold, 01 increment, 10 load target_in, 11 load jr_addr.
- rom_enable  input  1  IR load enable from the decoder.
- rom_data  input  IW  asynchronous ROM read data for address rom_addr.
- target_in  input  PC_W  absolute branch/jump target from the datapath.
- jr_addr  input  PC_W  register value for jump-register.
- rom_addr  output  PC_W  equals pc (registered).
- pc  output  PC_W  program counter.
- instr  output  IW  instruction register, drives the decoder.
- state  output  1  state flop, drives the decoder's state input.
- ir_valid  output  1  IR holds a fetched instruction. The datapath gates RW/MW with it.
- link_pc  output  PC_W  return address for jump-and-link. Equals pc.
- halted  output  1  sticky EOE flag.
- retired  output  CNT_W  count of IR loads, saturating.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): pc=0, instr=0, state=0, ir_valid=0, halted=0, retired=0. rst overrides every other input, including mid-branch (state=1) and halted=1.
- Pipeline model: the IR executes the instruction at pc-1, and pc already points to the next word. link_pc therefore equals pc.
- Per edge when not halted:
  - state <= ns.
  - When rom_enable=1: instr <= rom_data (that is, ROM[pc] before update), ir_valid <= 1, retired <= retired+1, saturating at all-ones.
  - When rom_enable=0: instr, ir_valid and retired hold.
  - PC update, computed from the pre-edge pc:
    - ps=00: hold.
    - ps=01: pc+1, modulo 2^PC_W (0xFF -> 0x00 at default).
    - ps=10: target_in.
    - ps=11: jr_addr.
- First cycle after reset: the decoder sees instr=0 with ir_valid=0 and issues ps=01, rom_enable=1. The sequencer loads ROM[0] and pc becomes 1. No architectural write may occur while ir_valid=0.
- Two-cycle control-flow ops:
  - Cycle A (state=0): ns=1, IR held, pc <= target/jr_addr, or pc held if the branch is not taken (ps=00).
  - Cycle B (state=1): ps=01, rom_enable=1. IR <= ROM[new pc], pc <= new pc+1, state <= 0.
- Halt detection: ps=00 AND ns=0 AND rom_enable=0, sampled at an edge while not halted, sets halted <= 1 at that edge. pc, instr, state and retired are not updated on that edge.
- While halted=1, all state registers are frozen regardless of inputs. Only rst clears the halt.
- ps=00 with ns=1 is a not-taken branch, not a halt.
- No X propagation: ps/ns/rom_enable are always driven (decoder defaults are 0).

Test Plan:
- Reset, with ROM[0..3] = 0x12, 0x34, 0x56, 0x78 and the decoder model active -> after 4 edges: pc=4, instr=0x78, retired=4, ir_valid=1, state=0.
- Taken branch at pc=5 (IR=ROM[4]): edge 1 with ps=10, ns=1, rom_enable=0, target_in=0x20 -> pc=0x20, state=1, IR unchanged. Edge 2 with ps=01, rom_enable=1 -> instr=ROM[0x20], pc=0x21, state=0.
- Not-taken branch: ps=00, ns=1, rom_enable=0 at pc=9 -> pc=9, state=1, halted=0. Next edge with ps=01 -> instr=ROM[9], pc=10.
- JR: ps=11, jr_addr=0x40, ns=1 -> pc=0x40. link_pc sampled before the edge equals the old pc.
- EOE: ps=00, ns=0, rom_enable=0 at pc=0x33 -> halted=1. Then drive ps=01, rom_enable=1 for 10 cycles -> pc=0x33 and retired unchanged. Asserting rst -> all outputs return to reset values.
- Wrap and reset mid-branch:
  - pc=0xFF with ps=01 -> pc=0x00.
  - rst asserted while state=1 -> state=0, ir_valid=0.
  - retired preset near all-ones -> saturates at 0xFFFF.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer: PC, instruction register, two-cycle state flop and end-of-execution halt.
module program_sequencer #(
  parameter int PC_W  = 8,
  parameter int IW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ns,
  input  logic [1:0]       ps,
  input  logic             rom_enable,
  input  logic [IW-1:0]    rom_data,
  input  logic [PC_W-1:0]  target_in,
  input  logic [PC_W-1:0]  jr_addr,
  output logic [PC_W-1:0]  rom_addr,
  output logic [PC_W-1:0]  pc,
  output logic [IW-1:0]    instr,
  output logic             state,
  output logic             ir_valid,
  output logic [PC_W-1:0]  link_pc,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  logic [PC_W-1:0] pc_nxt;
  logic            eoe;
  always_comb begin
    pc_nxt = ps == 2'b00 ? pc :
             ps == 2'b01 ? pc + 1'b1 :
             ps == 2'b10 ? target_in : jr_addr;
    eoe    = ps == 2'b00 && !ns && !rom_enable;
  end
  assign rom_addr = pc;
  assign link_pc  = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      instr    <= '0;
      state    <= 1'b0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
      retired  <= '0;
    end else if (!halted) begin
      if (eoe) begin
        halted <= 1'b1;
      end else begin
        state <= ns;
        pc    <= pc_nxt;
        if (rom_enable) begin
          instr    <= rom_data;
          ir_valid <= 1'b1;
          retired  <= &retired ? retired : retired + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed checks of fetch, branches, JR, halt, wrap, reset and counter saturation.
module tb_program_sequencer;
  logic        clk = 0;
  logic        rst = 1;
  logic        ns = 0;
  logic [1:0]  ps = 0;
  logic        rom_enable = 0;
  logic [7:0]  rom_data;
  logic [7:0]  target_in = 0;
  logic [7:0]  jr_addr = 0;
  logic [7:0]  rom_addr, pc, instr, link_pc;
  logic        state, ir_valid, halted;
  logic [15:0] retired;
  logic [7:0]  s_rom_addr, s_pc, s_instr, s_link_pc;
  logic        s_state, s_ir_valid, s_halted;
  logic [3:0]  s_retired;
  logic [7:0]  rom [256];
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  program_sequencer dut (
    .clk(clk), .rst(rst), .ns(ns), .ps(ps), .rom_enable(rom_enable), .rom_data(rom_data),
    .target_in(target_in), .jr_addr(jr_addr), .rom_addr(rom_addr), .pc(pc), .instr(instr),
    .state(state), .ir_valid(ir_valid), .link_pc(link_pc), .halted(halted), .retired(retired)
  );

  program_sequencer #(.CNT_W(4)) sat (
    .clk(clk), .rst(rst), .ns(ns), .ps(ps), .rom_enable(rom_enable), .rom_data(rom_data),
    .target_in(target_in), .jr_addr(jr_addr), .rom_addr(s_rom_addr), .pc(s_pc), .instr(s_instr),
    .state(s_state), .ir_valid(s_ir_valid), .link_pc(s_link_pc), .halted(s_halted), .retired(s_retired)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask

  task automatic cyc(input logic [1:0] p, input logic n, input logic r);
    ps = p;
    ns = n;
    rom_enable = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 3);
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56; rom[3] = 8'h78;
    cyc(2'b01, 1'b1, 1'b1);
    cyc(2'b01, 1'b1, 1'b1);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_state", state, 0);
    chk("rst_irv", ir_valid, 0);
    chk("rst_halt", halted, 0);
    chk("rst_ret", retired, 0);
    rst = 0;
    repeat (4) cyc(2'b01, 1'b0, 1'b1);
    chk("fetch_pc", pc, 4);
    chk("fetch_instr", instr, 8'h78);
    chk("fetch_ret", retired, 4);
    chk("fetch_irv", ir_valid, 1);
    chk("fetch_state", state, 0);
    cyc(2'b01, 1'b0, 1'b1);
    chk("pc5", pc, 5);
    target_in = 8'h20;
    cyc(2'b10, 1'b1, 1'b0);
    chk("br_a_pc", pc, 8'h20);
    chk("br_a_state", state, 1);
    chk("br_a_instr", instr, rom[4]);
    cyc(2'b01, 1'b0, 1'b1);
    chk("br_b_instr", instr, rom[8'h20]);
    chk("br_b_pc", pc, 8'h21);
    chk("br_b_state", state, 0);
    target_in = 8'h08;
    cyc(2'b10, 1'b1, 1'b0);
    cyc(2'b01, 1'b0, 1'b1);
    chk("pc9", pc, 9);
    cyc(2'b00, 1'b1, 1'b0);
    chk("nt_pc", pc, 9);
    chk("nt_state", state, 1);
    chk("nt_halt", halted, 0);
    cyc(2'b01, 1'b0, 1'b1);
    chk("nt_instr", instr, rom[9]);
    chk("nt_pc2", pc, 10);
    chk("nt_ret", retired, 8);
    jr_addr = 8'h40;
    chk("jr_link", link_pc, 10);
    cyc(2'b11, 1'b1, 1'b0);
    chk("jr_pc", pc, 8'h40);
    chk("jr_addr", rom_addr, 8'h40);
    cyc(2'b01, 1'b0, 1'b1);
    chk("jr_instr", instr, rom[8'h40]);
    target_in = 8'h32;
    cyc(2'b10, 1'b1, 1'b0);
    cyc(2'b01, 1'b0, 1'b1);
    chk("pc33", pc, 8'h33);
    chk("ret10", retired, 10);
    cyc(2'b00, 1'b0, 1'b0);
    chk("eoe_halt", halted, 1);
    chk("eoe_pc", pc, 8'h33);
    repeat (10) cyc(2'b01, 1'b1, 1'b1);
    chk("frz_pc", pc, 8'h33);
    chk("frz_ret", retired, 10);
    chk("frz_instr", instr, rom[8'h32]);
    chk("frz_state", state, 0);
    chk("frz_halt", halted, 1);
    rst = 1;
    cyc(2'b01, 1'b1, 1'b1);
    chk("hrst_halt", halted, 0);
    chk("hrst_pc", pc, 0);
    chk("hrst_instr", instr, 0);
    chk("hrst_ret", retired, 0);
    chk("hrst_irv", ir_valid, 0);
    rst = 0;
    target_in = 8'hFF;
    cyc(2'b10, 1'b1, 1'b0);
    chk("wrap_pre", pc, 8'hFF);
    cyc(2'b01, 1'b0, 1'b1);
    chk("wrap_pc", pc, 0);
    chk("wrap_instr", instr, rom[8'hFF]);
    target_in = 8'h10;
    cyc(2'b10, 1'b1, 1'b0);
    chk("mid_state", state, 1);
    rst = 1;
    cyc(2'b10, 1'b1, 1'b0);
    chk("mid_state_rst", state, 0);
    chk("mid_irv_rst", ir_valid, 0);
    chk("mid_pc_rst", pc, 0);
    rst = 0;
    repeat (20) cyc(2'b01, 1'b0, 1'b1);
    chk("cnt_main", retired, 20);
    chk("cnt_sat", s_retired, 4'hF);
    chk("cnt_pc", pc, 20);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
